// File: rtl/aes_subbytes_multi.sv
// AES SubBytes engine: substitutes a DIMxDIM byte state array through the
// forward or inverse S-box, LANES bytes per clock, with a valid/ready
// handshake on both sides. The input is captured on accept, so upstream is
// free to change its ports while the substitution is running.
module aes_subbytes_multi #(
  parameter int STATE_ARRAY_DIMENSION = 4,
  parameter int LANES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid,
  input  logic inverse,
  input  logic [STATE_ARRAY_DIMENSION-1:0][STATE_ARRAY_DIMENSION-1:0][7:0] state_array,
  input  logic next_is_ready,
  output logic [STATE_ARRAY_DIMENSION-1:0][STATE_ARRAY_DIMENSION-1:0][7:0] state_array_out,
  output logic ready,
  output logic valid_out
);

  localparam int DIM    = STATE_ARRAY_DIMENSION;
  localparam int NBYTES = DIM * DIM;
  localparam int STEPS  = NBYTES / LANES;
  localparam int CW     = $clog2(STEPS) + 1;
  localparam int IW     = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  // Only power-of-two lane counts that evenly divide the state are supported.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_subbytes_multi: LANES must be 1, 2, 4, 8 or 16");
  end
  if ((NBYTES % LANES) != 0) begin : g_bad_split
    $error("aes_subbytes_multi: LANES must divide the number of state bytes");
  end

  // FIPS-197 forward S-box.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // FIPS-197 inverse S-box.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t              state;
  logic [CW-1:0]       step_cnt;
  logic                cap_inv;
  logic [NBYTES*8-1:0] in_flat;
  logic [NBYTES*8-1:0] cap_flat;
  logic [NBYTES*8-1:0] out_flat;

  logic [IW-1:0] lane_idx [LANES];
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

  // The state is handled internally as a flat byte vector in column-major
  // order (byte k = column*DIM + row), so a step simply walks consecutive k.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      assign in_flat[(c*DIM + r)*8 +: 8] = state_array[r][c];
      assign state_array_out[r][c]       = out_flat[(c*DIM + r)*8 +: 8];
    end
  end

  assign ready     = (state == IDLE);
  assign valid_out = (state == DONE);

  // One forward and one inverse lookup per lane on the captured bytes of the
  // current step; the captured mode picks which result is written back.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = IW'(step_cnt) * IW'(LANES) + IW'(l);
      if (lane_idx[l] < IW'(NBYTES)) begin
        lane_in[l] = cap_flat[{lane_idx[l], 3'b000} +: 8];
      end else begin
        lane_in[l] = 8'h00;
      end
      lane_out[l] = cap_inv ? INV_SBOX[lane_in[l]] : SBOX[lane_in[l]];
    end
  end

  // Control FSM plus capture and result registers; bytes not written in the
  // current step keep whatever the previous operation left there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      step_cnt <= '0;
      cap_flat <= '0;
      cap_inv  <= 1'b0;
      out_flat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            cap_flat <= in_flat;
            cap_inv  <= inverse;
            step_cnt <= '0;
            state    <= RUNNING;
          end
        end
        RUNNING: begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_idx[l] < IW'(NBYTES)) begin
              out_flat[{lane_idx[l], 3'b000} +: 8] <= lane_out[l];
            end
          end
          step_cnt <= step_cnt + CW'(1);
          if (step_cnt == LAST_STEP) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (next_is_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_subbytes_multi.sv
// Testbench for aes_subbytes_multi: four instances (LANES 1, 2, 4, 16) share
// one input stream. Expected results come from an S-box derived with GF(2^8)
// arithmetic and a transaction-level model of accept/complete/hand-off.
module tb_aes_subbytes_multi;

  localparam int NINST = 4;

  typedef struct packed {
    logic         vld;
    logic         nir;
    logic [127:0] res;
  } rec_t;

  logic clk;
  logic reset_n;
  logic valid;
  logic inverse;
  logic next_is_ready;
  logic [3:0][3:0][7:0] state_array;

  logic [3:0][3:0][7:0] sao     [NINST];
  logic                 ready_o [NINST];
  logic                 valid_o [NINST];

  logic [7:0] ref_sbox [256];
  logic [7:0] ref_inv  [256];

  rec_t rec_q [$];

  int checks     = 0;
  int passed     = 0;
  int edge_count = 0;

  logic         busy     [NINST] = '{default: 1'b0};
  int           acc_edge [NINST] = '{default: 0};
  logic [127:0] cur_r    [NINST] = '{default: '0};
  logic [127:0] last_r   [NINST] = '{default: '0};

  localparam logic [127:0] FIPS_IN  = 128'h08_48_f8_e9_2a_8d_c6_9a_2b_e2_f4_a0_be_e3_3d_19;
  localparam logic [127:0] FIPS_OUT = 128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int LN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    aes_subbytes_multi #(
      .STATE_ARRAY_DIMENSION(4),
      .LANES(LN)
    ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .valid(valid),
      .inverse(inverse),
      .state_array(state_array),
      .next_is_ready(next_is_ready),
      .state_array_out(sao[g]),
      .ready(ready_o[g]),
      .valid_out(valid_o[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lanes_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gf_mul(x, 8'(y)) == 8'h01) return 8'(y);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [3:0][3:0][7:0] to_packed(input logic [127:0] f);
    logic [3:0][3:0][7:0] p;
    for (int k = 0; k < 16; k++) p[k % 4][k / 4] = f[8*k +: 8];
    return p;
  endfunction

  function automatic logic [127:0] to_flat(input logic [3:0][3:0][7:0] p);
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[8*k +: 8] = p[k % 4][k / 4];
    return f;
  endfunction

  function automatic logic [127:0] model_subbytes(input logic [127:0] din, input logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = inv ? ref_inv[din[8*k +: 8]] : ref_sbox[din[8*k +: 8]];
    end
    return r;
  endfunction

  // Drive one cycle of inputs just after the rising edge and post the
  // expected result of that cycle's input for the monitor.
  task automatic applyStimulus(input logic vld, input logic inv, input logic nir,
                               input logic rstn, input logic [127:0] data);
    rec_t r;
    @(posedge clk);
    #1;
    reset_n       = rstn;
    valid         = vld;
    inverse       = inv;
    next_is_ready = nir;
    state_array   = to_packed(data);
    r.vld = vld;
    r.nir = nir;
    r.res = model_subbytes(data, inv);
    rec_q.push_back(r);
  endtask

  task automatic checkOutput(input string name, input int inst,
                             input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got === want) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s lanes=%0d edge=%0d got=%h want=%h",
               name, lanes_of(inst), edge_count, got, want);
    end
  endtask

  // Monitor: on every falling edge compare each instance against the
  // transaction model, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    rec_t         r;
    int           ln;
    int           steps;
    int           n;
    logic         exp_rdy;
    logic         exp_vld;
    logic [127:0] exp_data;
    edge_count++;
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
    end else begin
      r.vld = 1'b0;
      r.nir = 1'b1;
      r.res = '0;
    end
    for (int i = 0; i < NINST; i++) begin
      ln    = lanes_of(i);
      steps = 16 / ln;
      if (!reset_n) begin
        checkOutput("reset_ready", i, 128'(ready_o[i]), 128'd1);
        checkOutput("reset_valid", i, 128'(valid_o[i]), 128'd0);
        checkOutput("reset_data",  i, to_flat(sao[i]),  128'd0);
        busy[i]   = 1'b0;
        last_r[i] = '0;
      end else begin
        n       = busy[i] ? (edge_count - acc_edge[i]) : 0;
        exp_rdy = !busy[i];
        exp_vld = busy[i] && (n >= steps);
        for (int k = 0; k < 16; k++) begin
          exp_data[8*k +: 8] = (busy[i] && (k < n * ln)) ? cur_r[i][8*k +: 8] : last_r[i][8*k +: 8];
        end
        checkOutput("ready", i, 128'(ready_o[i]), 128'(exp_rdy));
        checkOutput("valid_out", i, 128'(valid_o[i]), 128'(exp_vld));
        checkOutput("data", i, to_flat(sao[i]), exp_data);
        if (exp_vld && r.nir) begin
          busy[i]   = 1'b0;
          last_r[i] = cur_r[i];
        end else if (!busy[i] && r.vld) begin
          busy[i]     = 1'b1;
          acc_edge[i] = edge_count + 1;
          cur_r[i]    = r.res;
        end
      end
    end
  end

  // Stimulus sequence: known-answer vectors, hold/stall, input churn while
  // busy, mid-operation reset, back-to-back traffic, then random traffic.
  initial begin
    logic [7:0] s;
    valid         = 1'b0;
    inverse       = 1'b0;
    next_is_ready = 1'b1;
    state_array   = '0;
    reset_n       = 1'b1;
    #2 reset_n    = 1'b0;

    for (int x = 0; x < 256; x++) begin
      s = affine(gf_inv(8'(x)));
      ref_sbox[x] = s;
      ref_inv[s]  = 8'(x);
    end

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, FIPS_IN);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FIPS_OUT);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);
    repeat (29) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, FIPS_IN);
    repeat (20) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1,
                              {$urandom, $urandom, $urandom, $urandom});

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, FIPS_IN);
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, FIPS_IN);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);

    repeat (60) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, {16{8'h53}});
    repeat (60) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, {16{8'hed}});

    repeat (300) applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 9) < 7), 1'b1,
                               {$urandom, $urandom, $urandom, $urandom});

    repeat (30) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
    @(negedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
